// File: rtl/renorm_sequencer_if.sv
// Handshake bundle between the interval-update stage, renorm_sequencer and the byte sink.
// stat_symbols/stat_bytes exist only when RENORM_STATS_EN is defined.
interface renorm_sequencer_if #(
  parameter int RANGE_WIDTH = 16,
  parameter int D_SIZE      = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [RANGE_WIDTH-1:0] in_range;
  logic [RANGE_WIDTH-1:0] in_low;
  logic                   fb_valid;
  logic [RANGE_WIDTH-1:0] fb_range;
  logic [RANGE_WIDTH-1:0] fb_low;
  logic [D_SIZE-1:0]      fb_d;
  logic                   byte_valid;
  logic                   byte_ready;
  logic [7:0]             byte_data;
  logic                   flush_req;
  logic                   flush_done;
  logic                   busy;
  logic                   zero_range_err;
`ifdef RENORM_STATS_EN
  logic [31:0]            stat_symbols;
  logic [31:0]            stat_bytes;
`endif

  modport master (
    output in_valid, in_range, in_low, byte_ready, flush_req,
    input  in_ready, fb_valid, fb_range, fb_low, fb_d,
           byte_valid, byte_data, flush_done, busy, zero_range_err
`ifdef RENORM_STATS_EN
    , input stat_symbols, stat_bytes
`endif
  );

  modport slave (
    input  in_valid, in_range, in_low, byte_ready, flush_req,
    output in_ready, fb_valid, fb_range, fb_low, fb_d,
           byte_valid, byte_data, flush_done, busy, zero_range_err
`ifdef RENORM_STATS_EN
    , output stat_symbols, stat_bytes
`endif
  );
endinterface

// File: rtl/renorm_sequencer.sv
// AV1 range/low renormalizer: shifts by leading-zero count and packs shifted-out low bits
// MSB-first into bytes. Define RENORM_STATS_EN to add symbol/byte counters.
//
// state | meaning
// IDLE  | no symbol in progress, fewer than 8 pending bits
// RUN   | symbols arriving or whole bytes pending
// FLUSH | input blocked; pad to byte boundary and drain all pending bits
module renorm_sequencer #(
  parameter int RANGE_WIDTH = 16,
  parameter int D_SIZE      = 5,
  parameter int ACC_WIDTH   = 32,
  parameter int CNT_SIZE    = 6
) (
  input logic              general_clk,
  input logic              reset,
  renorm_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [CNT_SIZE-1:0] READY_LIMIT = CNT_SIZE'(ACC_WIDTH - RANGE_WIDTH);
  localparam logic [CNT_SIZE-1:0] BYTE_BITS   = CNT_SIZE'(8);

  state_t                 state, state_next;
  logic [ACC_WIDTH-1:0]   acc, acc_next;
  logic [CNT_SIZE-1:0]    cnt, cnt_next;
  logic [D_SIZE-1:0]      d;
  logic [ACC_WIDTH-1:0]   low_bits;
  logic [CNT_SIZE-1:0]    cnt_rounded;
  logic [2:0]             pad_amt;
  logic                   pad_needed;
  logic                   accept;
  logic                   byte_xfer;
  logic                   byte_valid;
  logic                   in_ready;
  logic [7:0]             byte_data;
  logic                   fb_valid_q;
  logic [RANGE_WIDTH-1:0] fb_range_q;
  logic [RANGE_WIDTH-1:0] fb_low_q;
  logic [D_SIZE-1:0]      fb_d_q;
  logic                   zero_err_q;

  // Highest set bit wins; an all-zero range leaves d at 0.
  always_comb begin
    d = '0;
    for (int i = 0; i < RANGE_WIDTH; i++) begin
      if (bus.in_range[i]) d = D_SIZE'(RANGE_WIDTH - 1 - i);
    end
  end

  assign low_bits    = ACC_WIDTH'(bus.in_low) >> (RANGE_WIDTH - int'(d));
  assign pad_needed  = (cnt[2:0] != 3'd0);
  assign pad_amt     = 3'(4'd8 - {1'b0, cnt[2:0]});
  assign cnt_rounded = {cnt[CNT_SIZE-1:3] + 1'b1, 3'b000};

  assign in_ready   = (state != FLUSH) && (cnt <= READY_LIMIT);
  assign byte_valid = (cnt >= BYTE_BITS) && !(state == FLUSH && pad_needed);
  assign accept     = bus.in_valid && in_ready;
  assign byte_xfer  = byte_valid && bus.byte_ready;
  assign byte_data  = byte_valid ? 8'(acc >> (cnt - BYTE_BITS)) : 8'h00;

  // Bits above cnt are stale and simply shift out of the top of acc.
  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    if (state == FLUSH && pad_needed) begin
      acc_next = acc << pad_amt;
      cnt_next = cnt_rounded;
    end else begin
      if (accept) acc_next = (acc << d) | low_bits;
      cnt_next = cnt + (accept ? CNT_SIZE'(d) : '0) - (byte_xfer ? BYTE_BITS : '0);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.flush_req)  state_next = FLUSH;
        else if (accept)    state_next = RUN;
      end
      RUN: begin
        if (bus.flush_req)                     state_next = FLUSH;
        else if (!accept && cnt < BYTE_BITS)   state_next = IDLE;
      end
      FLUSH: begin
        if (cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      fb_valid_q <= 1'b0;
      fb_range_q <= '0;
      fb_low_q   <= '0;
      fb_d_q     <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      cnt        <= cnt_next;
      fb_valid_q <= accept;
      if (accept) begin
        fb_range_q <= bus.in_range << d;
        fb_low_q   <= bus.in_low << d;
        fb_d_q     <= d;
        if (bus.in_range == '0) zero_err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.fb_valid       = fb_valid_q;
  assign bus.fb_range       = fb_range_q;
  assign bus.fb_low         = fb_low_q;
  assign bus.fb_d           = fb_d_q;
  assign bus.byte_valid     = byte_valid;
  assign bus.byte_data      = byte_data;
  assign bus.flush_done     = (state == FLUSH) && (cnt == '0);
  assign bus.busy           = (state != IDLE) || (cnt != '0);
  assign bus.zero_range_err = zero_err_q;

`ifdef RENORM_STATS_EN
  logic [31:0] stat_symbols_q;
  logic [31:0] stat_bytes_q;

  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      stat_symbols_q <= '0;
      stat_bytes_q   <= '0;
    end else begin
      if (accept && stat_symbols_q != '1)  stat_symbols_q <= stat_symbols_q + 32'd1;
      if (byte_xfer && stat_bytes_q != '1) stat_bytes_q   <= stat_bytes_q + 32'd1;
    end
  end

  assign bus.stat_symbols = stat_symbols_q;
  assign bus.stat_bytes   = stat_bytes_q;
`endif
endmodule

// File: tb/tb_renorm_sequencer.sv
// Scoreboard bench for renorm_sequencer: directed pairs push expected feedback and bytes,
// a negedge monitor pops and compares whenever fb_valid or a byte transfer is presented.
module tb_renorm_sequencer;
  logic general_clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  int lat;

  typedef struct packed {
    logic [15:0] range_v;
    logic [15:0] low_v;
    logic [4:0]  d_v;
  } fb_exp_t;

  fb_exp_t    fb_q[$];
  logic [7:0] byte_q[$];

  renorm_sequencer_if #(.RANGE_WIDTH(16), .D_SIZE(5)) bus ();

  renorm_sequencer #(
    .RANGE_WIDTH(16), .D_SIZE(5), .ACC_WIDTH(32), .CNT_SIZE(6)
  ) dut (
    .general_clk(general_clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 general_clk = ~general_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge general_clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_in_ready"},   32'(bus.in_ready), 32'd1);
    check({name, "_fb_valid"},   32'(bus.fb_valid), 32'd0);
    check({name, "_fb_range"},   32'(bus.fb_range), 32'd0);
    check({name, "_fb_low"},     32'(bus.fb_low), 32'd0);
    check({name, "_fb_d"},       32'(bus.fb_d), 32'd0);
    check({name, "_byte_valid"}, 32'(bus.byte_valid), 32'd0);
    check({name, "_byte_data"},  32'(bus.byte_data), 32'd0);
    check({name, "_flush_done"}, 32'(bus.flush_done), 32'd0);
    check({name, "_busy"},       32'(bus.busy), 32'd0);
    check({name, "_zero_err"},   32'(bus.zero_range_err), 32'd0);
  endtask

  task automatic send_pair(input logic [15:0] r, input logic [15:0] l,
                           input logic [15:0] er, input logic [15:0] el, input logic [4:0] ed);
    int k;
    k = 0;
    fb_q.push_back(fb_exp_t'({er, el, ed}));
    bus.in_range = r;
    bus.in_low   = l;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && k < 64) begin
      tick();
      k++;
    end
    check("accept_wait", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_flush(input string name, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    while (!seen && cycles < 64) begin
      @(negedge general_clk);
      cycles++;
      seen = bus.flush_done;
    end
    check({name, "_done"}, 32'(seen), 32'd1);
    @(negedge general_clk);
    check({name, "_pulse"}, 32'(bus.flush_done), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  // Monitor: compares every presented feedback pair and every transferred byte.
  initial begin
    forever begin
      @(negedge general_clk);
      if (!reset) begin
        if (bus.fb_valid) begin
          if (fb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL fb_unexpected: actual fb_range=%0h fb_low=%0h required no feedback",
                     bus.fb_range, bus.fb_low);
          end else begin
            fb_exp_t e;
            e = fb_q.pop_front();
            check("fb_range", 32'(bus.fb_range), 32'(e.range_v));
            check("fb_low",   32'(bus.fb_low),   32'(e.low_v));
            check("fb_d",     32'(bus.fb_d),     32'(e.d_v));
          end
        end
        if (bus.byte_valid && bus.byte_ready) begin
          if (byte_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL byte_unexpected: actual byte_data=%0h required no byte", bus.byte_data);
          end else begin
            logic [7:0] eb;
            eb = byte_q.pop_front();
            check("byte_data", 32'(bus.byte_data), 32'(eb));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_range   = '0;
    bus.in_low     = '0;
    bus.byte_ready = 1'b0;
    bus.flush_req  = 1'b0;
    #2;
    check_idle_outputs("reset0");
    tick();
    reset = 1'b0;
    tick();

    // Two symbols, one byte emitted, flush pads the trailing nibble.
    bus.byte_ready = 1'b1;
    byte_q.push_back(8'hA3);
    byte_q.push_back(8'hC0);
    send_pair(16'h0800, 16'hABCD, 16'h8000, 16'hBCD0, 5'd4);
    @(negedge general_clk);
    check("t2_cnt4_no_byte", 32'(bus.byte_valid), 32'd0);
    send_pair(16'h00F0, 16'h3C5A, 16'hF000, 16'h5A00, 5'd8);
    do_flush("t2_flush", lat);

    // Worst-case d=15 under full backpressure.
    bus.byte_ready = 1'b0;
    byte_q.push_back(8'h24);
    byte_q.push_back(8'h69);
    byte_q.push_back(8'h59);
    byte_q.push_back(8'hE0);
    byte_q.push_back(8'hD5);
    byte_q.push_back(8'hE0);
    send_pair(16'h0001, 16'h2469, 16'h8000, 16'h8000, 5'd15);
    send_pair(16'h0001, 16'hACF1, 16'h8000, 16'h8000, 5'd15);
    @(negedge general_clk);
    check("t3_ready_low_at_30", 32'(bus.in_ready), 32'd0);
    check("t3_byte_pending", 32'(bus.byte_valid), 32'd1);
    fb_q.push_back(fb_exp_t'({16'h8000, 16'h8000, 5'd15}));
    bus.in_range = 16'h0001;
    bus.in_low   = 16'h3579;
    bus.in_valid = 1'b1;
    repeat (3) tick();
    check("t3_third_stalled", 32'(bus.in_ready), 32'd0);
    check("t3_third_fb_pending", 32'(fb_q.size()), 32'd1);
    bus.byte_ready = 1'b1;
    begin
      int k;
      k = 0;
      while (!bus.in_ready && k < 64) begin
        tick();
        k++;
      end
    end
    check("t3_ready_after_drain", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    do_flush("t3_flush", lat);

    // d=0 leaves the pending bits alone; zero range sets the sticky error.
    check("t4_err_clear", 32'(bus.zero_range_err), 32'd0);
    send_pair(16'h8000, 16'h1357, 16'h8000, 16'h1357, 5'd0);
    @(negedge general_clk);
    check("t4_d0_no_byte", 32'(bus.byte_valid), 32'd0);
    send_pair(16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 5'd0);
    @(negedge general_clk);
    check("t4_zero_err_set", 32'(bus.zero_range_err), 32'd1);
    do_flush("t4_flush", lat);
    check("t4_flush_empty_latency", 32'(lat), 32'd1);

    // Accept d=8 together with a byte transfer at cnt=10.
    bus.byte_ready = 1'b0;
    byte_q.push_back(8'hB2);
    byte_q.push_back(8'hDB);
    byte_q.push_back(8'h80);
    send_pair(16'h0020, 16'hB2C5, 16'h8000, 16'h1400, 5'd10);
    fb_q.push_back(fb_exp_t'({16'hC300, 16'h9100, 5'd8}));
    bus.in_range   = 16'h00C3;
    bus.in_low     = 16'h6E91;
    bus.in_valid   = 1'b1;
    bus.byte_ready = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    bus.byte_ready = 1'b0;
    @(negedge general_clk);
    check("t5_cnt10_valid", 32'(bus.byte_valid), 32'd1);
    check("t5_cnt10_data", 32'(bus.byte_data), 32'hDB);
    check("t5_zero_err_sticky", 32'(bus.zero_range_err), 32'd1);
    tick();
    bus.byte_ready = 1'b1;
    do_flush("t5_flush", lat);

    // Asynchronous reset while in FLUSH with cnt=12.
    bus.byte_ready = 1'b0;
    send_pair(16'h0008, 16'hA5F5, 16'h8000, 16'h5000, 5'd12);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    check("t6_flush_ready_low", 32'(bus.in_ready), 32'd0);
    check("t6_flush_busy", 32'(bus.busy), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_idle_outputs("t6_reset");
    tick();
    reset = 1'b0;
    repeat (3) tick();

    check("fb_queue_drained", 32'(fb_q.size()), 32'd0);
    check("byte_queue_drained", 32'(byte_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/renorm_sequencer.md
Name: renorm_sequencer

Overview:
Sequences range/low renormalization for the AV1 arithmetic encoder around a leading-zero count of the updated range. Accepts one (range, low) pair per symbol from the interval-update stage and shifts both left by the leading-zero count d. It returns the normalized pair to the update stage and packs the shifted-out low bits into a byte stream for the carry-resolution/bitstream stage. It also provides an end-of-frame flush.

Parameters:
RANGE_WIDTH, 16, width of range and low inputs
D_SIZE, 5, width of shift amount d (must hold 0..RANGE_WIDTH)
ACC_WIDTH, 32, pending-bit accumulator width (>= RANGE_WIDTH+8)
CNT_SIZE, 6, width of pending-bit counter (holds 0..ACC_WIDTH)

Ports:
general_clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  upstream pair valid
in_ready  out  1  block can accept pair
in_range  in  RANGE_WIDTH  updated range, unnormalized
in_low  in  RANGE_WIDTH  updated low, unnormalized
fb_valid  out  1  one-cycle pulse: normalized pair valid
fb_range  out  RANGE_WIDTH  in_range << d
fb_low  out  RANGE_WIDTH  in_low << d, truncated
fb_d  out  D_SIZE  shift applied
byte_valid  out  1  pending byte available
byte_ready  in  1  downstream accepts byte
byte_data  out  8  oldest pending byte, MSB-first
flush_req  in  1  pulse: pad and drain all pending bits
flush_done  out  1  one-cycle pulse after last flush byte
busy  out  1  state != IDLE or cnt != 0
zero_range_err  out  1  sticky: in_range==0 was accepted

Behaviour:
- Reset: every output 0 except in_ready=1; acc=0, cnt=0, state IDLE. Async assert; all regs cleared regardless of in-flight operation.
- d = leading-zero count of in_range (0..RANGE_WIDTH-1). in_range==0: d=0, fb_range=0, zero_range_err set until reset.
- Accept on in_valid && in_ready. Next cycle: fb_valid=1, fb_range/fb_low/fb_d registered (latency 1). fb_* hold value until the next accept.
- Accept also performs acc = (acc << d) | (in_low >> (RANGE_WIDTH-d)) and cnt += d; d=0 leaves acc/cnt unchanged.
- byte_valid = (cnt >= 8) in IDLE/RUN. byte_data = acc[cnt-1 -: 8].
- Byte transfer on byte_valid && byte_ready: cnt -= 8.
- Accept and byte transfer in the same cycle: cnt_next = cnt + d - 8. The emitted byte is the pre-shift oldest byte.
- in_ready = (state != FLUSH) && (cnt <= ACC_WIDTH - RANGE_WIDTH). This guarantees no accumulator overflow for worst-case d=15 under full backpressure.
- FSM:
  - IDLE: accept sets state RUN.
  - RUN: returns to IDLE when cnt < 8 and no accept occurs.
  - flush_req in IDLE/RUN moves to FLUSH; an accept in the same cycle is taken first.
  - FLUSH: in_ready=0. If cnt mod 8 != 0, pad with zeros to the next byte boundary (cnt rounded up, acc shifted left). Emit all bytes normally; when cnt==0, pulse flush_done and go to IDLE.
  - flush_req with cnt==0: flush_done on the next cycle.
  - flush_req during FLUSH is ignored.
- Bits never lost or reordered; carry propagation is out of scope (handled downstream).

Optional Feature:
RENORM_STATS_EN: when defined, adds outputs stat_symbols (32-bit count of accepted pairs) and stat_bytes (32-bit count of transferred bytes). Both counters reset to 0 and saturate at all-ones. When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-FLUSH with cnt=12: all outputs 0, in_ready=1, zero_range_err=0 immediately on reset assert (async).
- in_range=0x0800, in_low=0xABCD -> next cycle fb_valid=1, fb_range=0x8000, fb_low=0xBCD0, fb_d=4; cnt=4, byte_valid=0.
- Then in_range=0x00F0, in_low=0x3C5A -> fb_range=0xF000, fb_low=0x5A00, fb_d=8; byte_data=0xA3 transferred. Then flush_req -> byte 0xC0, then flush_done pulse, busy=0.
- byte_ready=0; feed three pairs of in_range=0x0001 (d=15):
  - first two accepted (cnt 15, 30);
  - in_ready=0 at cnt=30, third stalls;
  - raising byte_ready drains to cnt<=16, the third is accepted, and the byte order matches the bit order.
- in_range=0x8000 (d=0) -> fb_d=0, cnt unchanged, no byte. in_range=0 -> zero_range_err=1, stays 1 through further traffic.
- Simultaneous accept (d=8) and byte transfer with cnt=10: next cnt=10. The emitted byte is the old top byte.
